// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, opcodes
// and the signed immediate ranges each format can represent.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_X6 = 3'd6,
    FMT_X7 = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  // Branch and jump offsets are even, so their upper limits stop one short
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic imm_in_range(input logic signed [31:0] v,
                                        input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_scatter.sv
// Combinational field packer: places registers, funct fields and immediate
// bits into the RV32I word for the requested format and flags bad immediates.
module imm_scatter
  import instr_encoder_pkg::*;
(
  input  logic        [2:0]  fmt,
  input  logic        [6:0]  op,
  input  logic        [4:0]  rd,
  input  logic        [4:0]  rs1,
  input  logic        [4:0]  rs2,
  input  logic        [2:0]  funct3,
  input  logic        [6:0]  funct7,
  input  logic signed [31:0] imm,
  output logic        [31:0] instr,
  output logic               err
);

  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, op};
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, op};
        err   = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        err   = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        err   = !imm_in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, op};
        err   = |imm[11:0];
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        err   = !imm_in_range(imm, IMM21_MIN, IMM21_MAX) || imm[0];
      end
      default: begin
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one output register stage with valid/ready
// handshake, sequential byte addressing and a saturating error counter.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic signed [31:0] imm_s;
  logic        [31:0] enc_instr;
  logic               enc_err;
  logic               accept;
  logic               consume;

  logic               vld_p0;
  logic        [31:0] instr_p0;
  logic               err_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [ADDR_W-1:0]  next_addr;
  logic        [7:0]  err_cnt_q;

  assign imm_s = $signed(in_imm);

  imm_scatter u_scatter (
    .fmt    (in_fmt),
    .op     (in_op),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (imm_s),
    .instr  (enc_instr),
    .err    (enc_err)
  );

  assign in_ready = !vld_p0 || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = vld_p0 && out_ready;

  // Stage p0: output register; address is bound to the word at accept time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      instr_p0  <= '0;
      err_p0    <= 1'b0;
      addr_p0   <= ADDR_W'(BASE_ADDR);
      next_addr <= ADDR_W'(BASE_ADDR);
      err_cnt_q <= '0;
    end else begin
      if (consume && err_p0)
        err_cnt_q <= sat_inc8(err_cnt_q);
      if (accept) begin
        vld_p0    <= 1'b1;
        instr_p0  <= enc_instr;
        err_p0    <= enc_err;
        addr_p0   <= next_addr;
        next_addr <= next_addr + ADDR_W'(4);
      end else if (consume) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_instr = instr_p0;
  assign out_err   = err_p0;
  assign out_addr  = addr_p0;
  assign err_cnt   = err_cnt_q;

endmodule
